id_ex_hazard_register: RTL and testbench

ID/EX pipeline register for the 5-stage RV32I core, with integrated load-use hazard detection and flush handling. It consumes the instruction and PC from the IF/ID register, plus the decoded operands and control bundle from the ID stage. It registers them for the EX stage. It also drives the stall/flush controls back to the PC register and the IF/ID register.

---
 rtl/id_ex_hazard_register.sv | 165 ++++++++++++++++
 tb/tb_id_ex_hazard_register.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_register.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_register
//
// ID/EX pipeline register for the 5-stage RV32I core. It also detects
// load-use hazards and handles EX-stage flushes. State updates on the
// falling clock edge, which is the same edge the IF/ID register uses.
//
// Ports:
//   clk, reset         clock (falling-edge active), async active-low reset
//   enable             global pipeline advance; 0 freezes every register
//   flush              taken branch/jump resolved in EX
//   id_instr, id_pc    instruction word and PC from IF/ID
//   id_rs1_data,
//   id_rs2_data,
//   id_imm, id_ctrl    decoded operands, immediate and control bundle
//   ex_*               registered copies for the EX stage
//   stall              load-use stall this cycle
//   pc_write           PC register enable
//   if_id_write        IF/ID register enable
//   if_id_flush        IF/ID clear request
//   stall_count,
//   flush_count        saturating event counters (HAZARD_STATS_EN only)
//
// Control bundle: [10] reg_write, [9] mem_to_reg, [8] mem_read,
// [7] mem_write, [6] branch, [5] jump, [4] alu_src, [3:0] alu_op.
//
// Optional feature macro: HAZARD_STATS_EN adds stall_count/flush_count.
// ---------------------------------------------------------------------------
module id_ex_hazard_register #(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  flush,
   input  logic [31:0]           id_instr,
   input  logic [DATA_WIDTH-1:0] id_pc,
   input  logic [DATA_WIDTH-1:0] id_rs1_data,
   input  logic [DATA_WIDTH-1:0] id_rs2_data,
   input  logic [DATA_WIDTH-1:0] id_imm,
   input  logic [CTRL_WIDTH-1:0] id_ctrl,
   output logic [DATA_WIDTH-1:0] ex_pc,
   output logic [DATA_WIDTH-1:0] ex_rs1_data,
   output logic [DATA_WIDTH-1:0] ex_rs2_data,
   output logic [DATA_WIDTH-1:0] ex_imm,
   output logic [4:0]            ex_rs1,
   output logic [4:0]            ex_rs2,
   output logic [4:0]            ex_rd,
   output logic [CTRL_WIDTH-1:0] ex_ctrl,
   output logic                  stall,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]           stall_count,
   output logic [31:0]           flush_count
`endif
);

   localparam int MEM_READ_BIT = 8;

   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic [4:0] id_rd;
   logic [6:0] opcode;
   logic       rs1_used;
   logic       rs2_used;
   logic       load_use;
   logic       bubble;
   logic       unused_instr_bits;

   assign id_rs1 = id_instr[19:15];
   assign id_rs2 = id_instr[24:20];
   assign id_rd  = id_instr[11:7];
   assign opcode = id_instr[6:0];

   // funct3/funct7 are decoded upstream; they are not needed here.
   assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

   // Work out which source indices the ID instruction actually reads, so a
   // match on an unused field (e.g. LUI's immediate bits) never stalls.
   always_comb begin
      rs1_used = 1'b1;
      rs2_used = 1'b0;
      case (opcode)
         7'b0110111, 7'b0010111, 7'b1101111: rs1_used = 1'b0;
         default:                            rs1_used = 1'b1;
      endcase
      case (opcode)
         7'b0110011, 7'b0100011, 7'b1100011: rs2_used = 1'b1;
         default:                            rs2_used = 1'b0;
      endcase
   end

   // A load in EX whose destination feeds the ID instruction must wait one
   // cycle. x0 is excluded via ex_rd != 0; a source index of 0 then can
   // never match either.
   assign load_use = ex_ctrl[MEM_READ_BIT] && (ex_rd != 5'd0) &&
                     ((rs1_used && (ex_rd == id_rs1)) ||
                      (rs2_used && (ex_rd == id_rs2)));

   // Flush wins: the instruction in ID is being discarded anyway.
   assign stall       = load_use & ~flush;
   assign pc_write    = enable & ~stall;
   assign if_id_write = enable & ~stall;
   assign if_id_flush = flush;
   assign bubble      = flush | stall;

   // Pipeline register: bubble on flush/stall, capture otherwise, hold
   // while the pipeline is frozen. The bubble clears mem_read, which is
   // what limits a load-use stall to a single cycle.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_ctrl     <= '0;
      end else if (enable) begin
         if (bubble) begin
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
         end else begin
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_ctrl;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   // Event counters advance only on edges where the pipeline moves, and
   // stick at all-ones rather than wrapping.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else if (enable) begin
         if (stall && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
         end
         if (flush && (flush_count != 32'hFFFF_FFFF)) begin
            flush_count <= flush_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_hazard_register.sv
// ---------------------------------------------------------------------------
// tb_id_ex_hazard_register
//
// Self-checking bench for id_ex_hazard_register. A behavioural model of the
// EX-stage contents is advanced alongside the DUT; directed scenarios cover
// reset, pass-through, load-use, x0/LUI non-stalls, flush priority and
// freeze, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_id_ex_hazard_register;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        flush;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_imm;
   logic [10:0] id_ctrl;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs1_data;
   logic [31:0] ex_rs2_data;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [4:0]  ex_rd;
   logic [10:0] ex_ctrl;
   logic        stall;
   logic        pc_write;
   logic        if_id_write;
   logic        if_id_flush;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count;
   logic [31:0] flush_count;
`endif

   int total;
   int bad;

   // Expected EX-stage contents.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [10:0] ctrl;
   } exState_t;

   exState_t model;
   int       modelStalls;
   int       modelFlushes;

   logic [6:0] opcodeList [10] = '{7'b0110011, 7'b0100011, 7'b1100011,
                                   7'b0110111, 7'b0010111, 7'b1101111,
                                   7'b0000011, 7'b0010011, 7'b1100111,
                                   7'b1110011};

   id_ex_hazard_register dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .flush       (flush),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_rs1_data (id_rs1_data),
      .id_rs2_data (id_rs2_data),
      .id_imm      (id_imm),
      .id_ctrl     (id_ctrl),
      .ex_pc       (ex_pc),
      .ex_rs1_data (ex_rs1_data),
      .ex_rs2_data (ex_rs2_data),
      .ex_imm      (ex_imm),
      .ex_rs1      (ex_rs1),
      .ex_rs2      (ex_rs2),
      .ex_rd       (ex_rd),
      .ex_ctrl     (ex_ctrl),
      .stall       (stall),
      .pc_write    (pc_write),
      .if_id_write (if_id_write),
      .if_id_flush (if_id_flush)
`ifdef HAZARD_STATS_EN
      ,
      .stall_count (stall_count),
      .flush_count (flush_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Load-use rule straight from the instruction semantics: does a pending
   // load's destination feed a source this instruction really reads?
   function automatic bit modelStall(input exState_t e, input logic [31:0] instr,
                                     input bit fl);
      logic [6:0] op;
      bit readsRs1;
      bit readsRs2;
      op = instr[6:0];
      readsRs1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
      readsRs2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
      if (fl || !e.ctrl[8] || e.rd == 5'd0) return 1'b0;
      return (readsRs1 && e.rd == instr[19:15]) ||
             (readsRs2 && e.rd == instr[24:20]);
   endfunction

   task automatic checkRegs(input string tag);
      checkOutput({tag, ".ex_pc"},   ex_pc,       model.pc);
      checkOutput({tag, ".ex_rs1d"}, ex_rs1_data, model.rs1d);
      checkOutput({tag, ".ex_rs2d"}, ex_rs2_data, model.rs2d);
      checkOutput({tag, ".ex_imm"},  ex_imm,      model.imm);
      checkOutput({tag, ".ex_rs1"},  {27'd0, ex_rs1}, {27'd0, model.rs1});
      checkOutput({tag, ".ex_rs2"},  {27'd0, ex_rs2}, {27'd0, model.rs2});
      checkOutput({tag, ".ex_rd"},   {27'd0, ex_rd},  {27'd0, model.rd});
      checkOutput({tag, ".ex_ctrl"}, {21'd0, ex_ctrl}, {21'd0, model.ctrl});
`ifdef HAZARD_STATS_EN
      checkOutput({tag, ".stall_count"}, stall_count, modelStalls);
      checkOutput({tag, ".flush_count"}, flush_count, modelFlushes);
`endif
   endtask

   // One pipeline cycle: drive ID inputs after the rising edge, check the
   // combinational hazard outputs, then check EX contents after the
   // falling edge.
   task automatic applyStimulus(input string tag, input logic [31:0] instr,
                                input logic [31:0] pc, input logic [10:0] ctrl,
                                input bit en, input bit fl);
      bit expStall;
      @(posedge clk);
      id_instr    = instr;
      id_pc       = pc;
      id_ctrl     = ctrl;
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm      = $urandom;
      enable      = en;
      flush       = fl;
      #1;
      expStall = modelStall(model, instr, fl);
      checkOutput({tag, ".stall"},       {31'd0, stall},       {31'd0, expStall});
      checkOutput({tag, ".pc_write"},    {31'd0, pc_write},    {31'd0, en && !expStall});
      checkOutput({tag, ".if_id_write"}, {31'd0, if_id_write}, {31'd0, en && !expStall});
      checkOutput({tag, ".if_id_flush"}, {31'd0, if_id_flush}, {31'd0, fl});
      @(negedge clk);
      if (en) begin
         if (expStall) modelStalls++;
         if (fl) modelFlushes++;
         if (fl || expStall) begin
            model = '0;
         end else begin
            model.pc   = pc;
            model.rs1d = id_rs1_data;
            model.rs2d = id_rs2_data;
            model.imm  = id_imm;
            model.rs1  = instr[19:15];
            model.rs2  = instr[24:20];
            model.rd   = instr[11:7];
            model.ctrl = ctrl;
         end
      end
      #1;
      checkRegs(tag);
   endtask

   function automatic logic [31:0] randomInstr();
      logic [31:0] w;
      w = $urandom;
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      w[11:7]  = 5'($urandom_range(0, 7));
      w[6:0]   = opcodeList[$urandom_range(0, 9)];
      return w;
   endfunction

   initial begin
      logic [10:0] rc;
      total        = 0;
      bad          = 0;
      model        = '0;
      modelStalls  = 0;
      modelFlushes = 0;
      reset        = 1'b0;
      enable       = 1'b1;
      flush        = 1'b0;
      id_instr     = 32'h0;
      id_pc        = 32'h0;
      id_rs1_data  = 32'h0;
      id_rs2_data  = 32'h0;
      id_imm       = 32'h0;
      id_ctrl      = 11'h0;
      #3;
      checkRegs("por");
      checkOutput("por.stall",    {31'd0, stall},    32'd0);
      checkOutput("por.pc_write", {31'd0, pc_write}, 32'd1);
      @(posedge clk);
      reset = 1'b1;

      // Pass-through of ADD x3,x1,x2.
      applyStimulus("add", 32'h002081B3, 32'h00400004, 11'h400, 1'b1, 1'b0);
      checkOutput("add.rd",  {27'd0, ex_rd},  32'd3);
      checkOutput("add.rs1", {27'd0, ex_rs1}, 32'd1);
      checkOutput("add.rs2", {27'd0, ex_rs2}, 32'd2);
      checkOutput("add.pc",  ex_pc, 32'h00400004);

      // LW x5 then ADD x6,x5,x1: one bubble, then the ADD is captured.
      applyStimulus("lw5", 32'h0000A283, 32'h00400008, 11'h700, 1'b1, 1'b0);
      applyStimulus("lu1", 32'h00128333, 32'h0040000C, 11'h400, 1'b1, 1'b0);
      checkOutput("lu1.bubble", {21'd0, ex_ctrl}, 32'd0);
      applyStimulus("lu2", 32'h00128333, 32'h0040000C, 11'h400, 1'b1, 1'b0);
      checkOutput("lu2.rd", {27'd0, ex_rd}, 32'd6);

      // Load to x0 never stalls; LUI x5 ignores its rs1 field.
      applyStimulus("lw0", 32'h00002003, 32'h00400010, 11'h700, 1'b1, 1'b0);
      applyStimulus("addi", 32'h00100093, 32'h00400014, 11'h410, 1'b1, 1'b0);
      checkOutput("addi.rd", {27'd0, ex_rd}, 32'd1);
      applyStimulus("lw5b", 32'h0000A283, 32'h00400018, 11'h700, 1'b1, 1'b0);
      applyStimulus("lui", 32'h000052B7, 32'h0040001C, 11'h410, 1'b1, 1'b0);
      checkOutput("lui.ctrl", {21'd0, ex_ctrl}, 32'h410);

      // Flush together with a load-use: flush wins.
      applyStimulus("lw5c", 32'h0000A283, 32'h00400020, 11'h700, 1'b1, 1'b0);
      applyStimulus("flu", 32'h00128333, 32'h00400024, 11'h400, 1'b1, 1'b1);
      checkOutput("flu.ctrl", {21'd0, ex_ctrl}, 32'd0);

      // Freeze for three edges with changing inputs, then resume.
      applyStimulus("pre", 32'h002081B3, 32'h00400028, 11'h400, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus("frz", randomInstr(), $urandom, 11'($urandom), 1'b0,
                       1'($urandom_range(0, 1)));
         checkOutput("frz.pc", ex_pc, 32'h00400028);
      end
      applyStimulus("resume", 32'h00128333, 32'h0040002C, 11'h400, 1'b1, 1'b0);
      checkOutput("resume.pc", ex_pc, 32'h0040002C);

      // Randomized run with frequent loads to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         rc = 11'($urandom);
         rc[8] = ($urandom_range(0, 1) == 1);
         applyStimulus("rnd", randomInstr(), $urandom, rc,
                       $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0);
      end

      // Asynchronous reset between edges with nonzero state loaded.
      applyStimulus("prerst", 32'h0000A283, 32'h00400030, 11'h700, 1'b1, 1'b0);
      @(posedge clk);
      id_instr = 32'h00128333;
      flush    = 1'b0;
      enable   = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      model        = '0;
      modelStalls  = 0;
      modelFlushes = 0;
      checkRegs("rst");
      checkOutput("rst.stall",       {31'd0, stall},       32'd0);
      checkOutput("rst.pc_write",    {31'd0, pc_write},    32'd1);
      checkOutput("rst.if_id_write", {31'd0, if_id_write}, 32'd1);
      #1;
      reset = 1'b1;
      applyStimulus("postrst", 32'h002081B3, 32'h00400034, 11'h400, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
